spi_slave_light: RTL and testbench
==================================

Name: spi_slave_light

Overview:
- SPI responder at the traffic-light end of the link; receives the 6-bit command frames sent by the system-side SPI master.
- Each frame carries cmd, a 2-bit address and 3-bit data. The block holds four 3-bit registers. Register 0 drives the lamps.
- Writes update a register. Reads return the register contents on spi_miso during the data phase of the same frame.
- spi_sclk, spi_mosi and spi_ss_n are asynchronous to clk. They are oversampled through synchronizers.

Parameters:
- SYNC_STAGES, 2, flip-flop stages per synchronized SPI input (minimum 2).
- REG0_RST, 3'b100, reset value of register 0 (red lamp on; bit2=red, bit1=yellow, bit0=green).

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset; synchronous, active-low.
- spi_sclk  input  1  SPI clock, mode 0 (idle low, sample on rising edge).
- spi_mosi  input  1  serial data from master, MSB first.
- spi_miso  output  1  serial data to master.
- spi_ss_n  input  1  active-low frame select.
- light  output  3  register 0 contents: {red, yellow, green}.
- reg1_q, reg2_q, reg3_q  output  3 each  registers 1..3.
- wr_valid  output  1  one-cycle pulse when a write frame commits.
- rd_valid  output  1  one-cycle pulse when a read frame completes.
- frame_err  output  1  one-cycle pulse when a frame is aborted short.

Behaviour:
- Reset: one clock is synchronous, active-low reset n_rst, sampled on the rising edge of clk.
  - light=REG0_RST; reg1_q..reg3_q=0; spi_miso=0; all pulses=0.
  - Bit counter=0; state=IDLE; synchronizers load idle values (sclk=0, ss_n=1).
- Frame format, MSB first, 6 bits: bit5 cmd (1=write, 0=read), bits4:3 addr, bits2:0 data.
- Input path: SYNC_STAGES flops per input, then one delay flop on sclk and ss_n for edge detection. Edge and level decisions use synchronized values only.
- Timing constraint: spi_sclk high and low times are each at least 4 clk cycles.
- Latency (SYNC_STAGES=2): if clk edge k first samples raw spi_sclk high, the rising edge is acted on at clk edge k+2.
- FSM states:
  - IDLE: wait for the synced ss_n falling edge. Clear the counter and shift register, then go to SHIFT.
  - SHIFT: on each synced sclk rising edge, shift in mosi and increment the counter.
    - At count 3: if cmd=0, load rd_shift <= reg[addr]. spi_miso takes rd_shift[2] on the next clk edge.
    - On each synced sclk falling edge after count 3: shift rd_shift left and update spi_miso. Data bits therefore appear on MISO in bit 2, 1, 0 order for the master's rising edges 4..6.
    - At count 6, write frame: reg[addr] <= data and wr_valid=1 for one cycle, both on the same clk edge. Then go to DONE.
    - At count 6, read frame: rd_valid=1 for one cycle. Then go to DONE.
  - DONE: ignore further sclk edges. Go to IDLE on the synced ss_n rising edge.
- Short frame: if ss_n rises in SHIFT with count<6, discard the frame, pulse frame_err for one cycle, make no register change, and return to IDLE.
- Extra clocks: more than 6 sclk edges in one frame are ignored; the first 6 bits stand.
- spi_miso is 0 in IDLE, in DONE, during bits 5..3, and throughout write frames. There is no tri-state.
- ss_n rising and the 6th sclk edge in the same clk cycle: the 6th bit completes the frame first, so no frame_err.
- sclk edges while ss_n is high (IDLE) are ignored.
- n_rst low mid-frame: abort. Registers return to reset values and no pulse is emitted.
- Registers change only on committed write frames.

Test Plan:
- Reset: hold n_rst=0 for 3 cycles -> light=3'b100, reg1_q..reg3_q=0, spi_miso=0, no pulses.
- Write frame bits 1,00,001 -> within 4 clk cycles of the 6th sclk rise: light=3'b001, wr_valid pulses exactly once; other registers unchanged.
- Write 1,10,101 to reg2, then read frame 0,10,000 -> MISO sampled on sclk rises 4..6 = 1,0,1. rd_valid pulses once. reg2_q stays 3'b101.
- Short frame: raise ss_n after 4 bits of 1,01,1.. -> frame_err pulses once, reg1_q unchanged, next full frame 1,01,110 -> reg1_q=3'b110.
- Extra clocks: send 8 sclk pulses 1,11,011,x,x -> reg3_q=3'b011, single wr_valid, no frame_err.
- Reset mid-frame: pull n_rst low after 3 bits -> no pulse, outputs at reset values. The next clean frame 1,00,010 -> light=3'b010.

Source files
------------

// File: rtl/spi_slave_light.sv
// SPI mode-0 responder for the traffic-light node: 6-bit frames {cmd, addr[1:0], data[2:0]}
// write or read one of four 3-bit registers; register 0 drives the lamps.
module spi_slave_light #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] REG0_RST    = 3'b100
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       spi_ss_n,
  output logic [2:0] light,
  output logic [2:0] reg1_q,
  output logic [2:0] reg2_q,
  output logic [2:0] reg3_q,
  output logic       wr_valid,
  output logic       rd_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_r, state_next_s;
  logic [SYNC_STAGES-1:0] sclk_sync_r, mosi_sync_r, ss_sync_r;
  logic                   sclk_d_r, ss_d_r;
  logic                   sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s, mosi_s;
  logic [2:0]             cnt_r;
  logic [4:0]             shift_r;
  logic [2:0]             rd_shift_r;
  logic                   is_rd_r;
  logic [2:0]             regs_r [4];
  logic                   miso_r, wr_valid_r, rd_valid_r, frame_err_r;
  logic                   clear_s, shift_en_s, last_bit_s, abort_s, miso_load_s, miso_fall_s;

  // Synchronizers plus one delay flop on sclk / ss_n for edge detection.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_d_r    <= 1'b0;
      ss_d_r      <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], spi_ss_n};
      sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
      ss_d_r      <= ss_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-1] & sclk_d_r;
  assign ss_fall_s   = ~ss_sync_r[SYNC_STAGES-1] & ss_d_r;
  assign ss_rise_s   = ss_sync_r[SYNC_STAGES-1] & ~ss_d_r;
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // A 6th bit coinciding with ss_n rising still completes; skip DONE since ss_n is already high.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ss_fall_s) state_next_s = ST_SHIFT;
        else           state_next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (sclk_rise_s && (cnt_r == 3'd5)) state_next_s = ss_rise_s ? ST_IDLE : ST_DONE;
        else if (ss_rise_s)                 state_next_s = ST_IDLE;
        else                                state_next_s = ST_SHIFT;
      end
      ST_DONE: begin
        if (ss_rise_s) state_next_s = ST_IDLE;
        else           state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  always_comb begin
    clear_s     = 1'b0;
    shift_en_s  = 1'b0;
    last_bit_s  = 1'b0;
    abort_s     = 1'b0;
    miso_load_s = 1'b0;
    miso_fall_s = 1'b0;
    case (state_r)
      ST_IDLE: clear_s = 1'b1;
      ST_SHIFT: begin
        shift_en_s  = sclk_rise_s;
        last_bit_s  = sclk_rise_s & (cnt_r == 3'd5);
        abort_s     = ss_rise_s & ~(sclk_rise_s & (cnt_r == 3'd5));
        miso_load_s = is_rd_r & (cnt_r == 3'd3);
        miso_fall_s = is_rd_r & sclk_fall_s & ((cnt_r == 3'd4) || (cnt_r == 3'd5));
      end
      ST_DONE: clear_s = 1'b0;
      default: clear_s = 1'b1;
    endcase
  end

  // Frame datapath, register file and registered outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_r       <= 3'd0;
      shift_r     <= 5'd0;
      rd_shift_r  <= 3'd0;
      is_rd_r     <= 1'b0;
      miso_r      <= 1'b0;
      wr_valid_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      regs_r[0]   <= REG0_RST;
      regs_r[1]   <= 3'd0;
      regs_r[2]   <= 3'd0;
      regs_r[3]   <= 3'd0;
    end else begin
      wr_valid_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (clear_s) begin
        cnt_r      <= 3'd0;
        shift_r    <= 5'd0;
        rd_shift_r <= 3'd0;
        is_rd_r    <= 1'b0;
        miso_r     <= 1'b0;
      end else if (abort_s) begin
        frame_err_r <= 1'b1;
        miso_r      <= 1'b0;
      end else if (last_bit_s) begin
        cnt_r  <= cnt_r + 3'd1;
        miso_r <= 1'b0;
        if (shift_r[4]) begin
          regs_r[shift_r[3:2]] <= {shift_r[1:0], mosi_s};
          wr_valid_r           <= 1'b1;
        end else begin
          rd_valid_r <= 1'b1;
        end
      end else if (shift_en_s) begin
        shift_r <= {shift_r[3:0], mosi_s};
        cnt_r   <= cnt_r + 3'd1;
        if ((cnt_r == 3'd2) && !shift_r[1]) begin
          is_rd_r    <= 1'b1;
          rd_shift_r <= regs_r[{shift_r[0], mosi_s}];
        end
      end else if (miso_fall_s) begin
        rd_shift_r <= {rd_shift_r[1:0], 1'b0};
        miso_r     <= rd_shift_r[1];
      end else if (miso_load_s) begin
        miso_r <= rd_shift_r[2];
      end
    end
  end

  assign spi_miso  = miso_r;
  assign light     = regs_r[0];
  assign reg1_q    = regs_r[1];
  assign reg2_q    = regs_r[2];
  assign reg3_q    = regs_r[3];
  assign wr_valid  = wr_valid_r;
  assign rd_valid  = rd_valid_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_light.sv
// Bench for spi_slave_light: acts as SPI master and compares against a register-array model.
module tb_spi_slave_light;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_miso;
  logic [2:0] light, reg1_q, reg2_q, reg3_q;
  logic       wr_valid, rd_valid, frame_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int err_seen = 0;
  logic [2:0] model [4];

  spi_slave_light #(.SYNC_STAGES(2), .REG0_RST(3'b100)) dut (
    .clk(clk), .n_rst(n_rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_ss_n(spi_ss_n), .light(light), .reg1_q(reg1_q),
    .reg2_q(reg2_q), .reg3_q(reg3_q), .wr_valid(wr_valid), .rd_valid(rd_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid)  wr_seen  <= wr_seen + 1;
    if (rd_valid)  rd_seen  <= rd_seen + 1;
    if (frame_err) err_seen <= err_seen + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bits are right-aligned, sent MSB (bits[nbits-1]) first; cap holds MISO at each rise.
  task automatic xfer(input logic [7:0] bits, input int nbits,
                      output logic [7:0] cap, output logic [11:0] snap);
    cap  = 8'd0;
    snap = 12'd0;
    spi_ss_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = bits[nbits-1-i];
      wait_clk(6);
      spi_sclk = 1'b1;
      cap[nbits-1-i] = spi_miso;
      if (i == 5) begin
        wait_clk(4);
        snap = {light, reg1_q, reg2_q, reg3_q};
        wait_clk(2);
      end else begin
        wait_clk(6);
      end
      spi_sclk = 1'b0;
    end
    wait_clk(6);
    spi_ss_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    wait_clk(3);
    total_cnt++;
    if ({light, reg1_q, reg2_q, reg3_q} !== {3'b100, 9'd0}) $display("FAIL reset_regs: got %h expected %h", {light, reg1_q, reg2_q, reg3_q}, {3'b100, 9'd0});
    else pass_cnt++;
    total_cnt++;
    if ({spi_miso, wr_valid, rd_valid, frame_err} !== 4'b0000) $display("FAIL reset_pulses: got %b expected 0000", {spi_miso, wr_valid, rd_valid, frame_err});
    else pass_cnt++;
    n_rst = 1'b1;
    wait_clk(3);
    model[0] = 3'b100; model[1] = 3'd0; model[2] = 3'd0; model[3] = 3'd0;
  endtask

  task automatic test_write_light;
    logic [7:0] cap; logic [11:0] snap; int w0;
    w0 = wr_seen;
    xfer(8'b00100001, 6, cap, snap);
    total_cnt++;
    if (snap !== {3'b001, 9'd0}) $display("FAIL write_light_early: got %h expected %h", snap, {3'b001, 9'd0});
    else pass_cnt++;
    total_cnt++;
    if (wr_seen - w0 !== 1) $display("FAIL write_light_wr_valid: got %0d expected 1", wr_seen - w0);
    else pass_cnt++;
    total_cnt++;
    if (cap !== 8'd0) $display("FAIL write_light_miso: got %b expected 0", cap);
    else pass_cnt++;
    model[0] = 3'b001;
  endtask

  task automatic test_read_back;
    logic [7:0] cap; logic [11:0] snap; int r0;
    xfer(8'b00110101, 6, cap, snap);
    r0 = rd_seen;
    xfer(8'b00010000, 6, cap, snap);
    total_cnt++;
    if (cap[5:0] !== 6'b000101) $display("FAIL read_miso: got %b expected 000101", cap[5:0]);
    else pass_cnt++;
    total_cnt++;
    if (rd_seen - r0 !== 1) $display("FAIL read_rd_valid: got %0d expected 1", rd_seen - r0);
    else pass_cnt++;
    total_cnt++;
    if (reg2_q !== 3'b101) $display("FAIL read_reg2: got %b expected 101", reg2_q);
    else pass_cnt++;
    model[2] = 3'b101;
  endtask

  task automatic test_short_frame;
    logic [7:0] cap; logic [11:0] snap; int e0, w0;
    e0 = err_seen; w0 = wr_seen;
    xfer(8'b00001011, 4, cap, snap);
    total_cnt++;
    if (err_seen - e0 !== 1 || wr_seen - w0 !== 0) $display("FAIL short_pulses: got err %0d wr %0d expected err 1 wr 0", err_seen - e0, wr_seen - w0);
    else pass_cnt++;
    total_cnt++;
    if (reg1_q !== 3'b000) $display("FAIL short_reg1: got %b expected 000", reg1_q);
    else pass_cnt++;
    xfer(8'b00101110, 6, cap, snap);
    total_cnt++;
    if (reg1_q !== 3'b110) $display("FAIL short_next_reg1: got %b expected 110", reg1_q);
    else pass_cnt++;
    model[1] = 3'b110;
  endtask

  task automatic test_extra_clocks;
    logic [7:0] cap; logic [11:0] snap; logic [7:0] bits; int e0, w0;
    e0 = err_seen; w0 = wr_seen;
    bits = {6'b111011, 2'($urandom_range(0, 3))};
    xfer(bits, 8, cap, snap);
    total_cnt++;
    if (reg3_q !== 3'b011) $display("FAIL extra_reg3: got %b expected 011", reg3_q);
    else pass_cnt++;
    total_cnt++;
    if (wr_seen - w0 !== 1 || err_seen - e0 !== 0) $display("FAIL extra_pulses: got wr %0d err %0d expected wr 1 err 0", wr_seen - w0, err_seen - e0);
    else pass_cnt++;
    model[3] = 3'b011;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] cap; logic [11:0] snap; logic [2:0] hdr; int p0;
    p0 = wr_seen + rd_seen + err_seen;
    hdr = 3'b100;
    spi_ss_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = hdr[2-i];
      wait_clk(6);
      spi_sclk = 1'b1;
      wait_clk(6);
      spi_sclk = 1'b0;
    end
    wait_clk(3);
    n_rst = 1'b0;
    spi_ss_n = 1'b1;
    wait_clk(3);
    n_rst = 1'b1;
    wait_clk(8);
    total_cnt++;
    if ({light, reg1_q, reg2_q, reg3_q, spi_miso} !== {3'b100, 9'd0, 1'b0}) $display("FAIL midrst_outputs: got %h expected %h", {light, reg1_q, reg2_q, reg3_q, spi_miso}, {3'b100, 9'd0, 1'b0});
    else pass_cnt++;
    total_cnt++;
    if (wr_seen + rd_seen + err_seen - p0 !== 0) $display("FAIL midrst_pulses: got %0d expected 0", wr_seen + rd_seen + err_seen - p0);
    else pass_cnt++;
    model[0] = 3'b100; model[1] = 3'd0; model[2] = 3'd0; model[3] = 3'd0;
    xfer(8'b00100010, 6, cap, snap);
    total_cnt++;
    if (light !== 3'b010) $display("FAIL midrst_next_light: got %b expected 010", light);
    else pass_cnt++;
    model[0] = 3'b010;
  endtask

  task automatic test_random;
    logic [7:0] bits, cap, exp_cap; logic [11:0] snap; logic [5:0] f; logic [1:0] a;
    int nbits, w0, r0, e0, ew, er, ee, sel;
    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      nbits = $urandom_range(1, 5);
      else if (sel == 1) nbits = $urandom_range(7, 8);
      else               nbits = 6;
      bits = 8'($urandom);
      exp_cap = 8'd0;
      ew = 0; er = 0; ee = 0;
      if (nbits >= 4 && bits[nbits-1] == 1'b0) begin
        a = {bits[nbits-2], bits[nbits-3]};
        for (int i = 3; i < 6 && i < nbits; i++) exp_cap[nbits-1-i] = model[a][5-i];
      end
      w0 = wr_seen; r0 = rd_seen; e0 = err_seen;
      xfer(bits, nbits, cap, snap);
      if (nbits < 6) begin
        ee = 1;
      end else begin
        f = 6'(bits >> (nbits - 6));
        if (f[5]) begin model[f[4:3]] = f[2:0]; ew = 1; end
        else er = 1;
        total_cnt++;
        if (snap !== {model[0], model[1], model[2], model[3]}) $display("FAIL rand_early_regs: got %h expected %h", snap, {model[0], model[1], model[2], model[3]});
        else pass_cnt++;
      end
      total_cnt++;
      if (cap !== exp_cap) $display("FAIL rand_miso: got %b expected %b (nbits %0d bits %b)", cap, exp_cap, nbits, bits);
      else pass_cnt++;
      total_cnt++;
      if ({light, reg1_q, reg2_q, reg3_q} !== {model[0], model[1], model[2], model[3]}) $display("FAIL rand_regs: got %h expected %h", {light, reg1_q, reg2_q, reg3_q}, {model[0], model[1], model[2], model[3]});
      else pass_cnt++;
      total_cnt++;
      if (wr_seen - w0 !== ew || rd_seen - r0 !== er || err_seen - e0 !== ee) $display("FAIL rand_pulses: got wr %0d rd %0d err %0d expected %0d %0d %0d", wr_seen - w0, rd_seen - r0, err_seen - e0, ew, er, ee);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_write_light();
    test_read_back();
    test_short_frame();
    test_extra_clocks();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
